// File: rtl/ucode_checkpoint_monitor_if.sv
// Retire/redirect bus between the microcode tracer/control unit and the
// checkpoint monitor. The master side is the CPU (tracer + control unit).
// The slave side is the monitor.
interface ucode_checkpoint_monitor_if #(
    parameter int PC_W = 12
);
    logic            ret_valid;
    logic [PC_W-1:0] ret_pc;
    logic            ret_cont;
    logic [PC_W-1:0] ret_cont_a;
    logic [PC_W-1:0] next_pc;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;

    modport master (
        output ret_valid, ret_pc, ret_cont, ret_cont_a, next_pc,
        input  redir_valid, redir_pc
    );

    modport slave (
        input  ret_valid, ret_pc, ret_cont, ret_cont_a, next_pc,
        output redir_valid, redir_pc
    );
endinterface

// File: rtl/ucode_checkpoint_monitor.sv
// Table-driven microcode checkpoint monitor.
// Retired microinstructions are matched against N_ENT programmable entries
// (PASS/FAIL/FINISH/SKIP/LOOP). The monitor produces registered event pulses,
// a sticky pass bitmap, a run verdict, a cycle-limit timeout and uPC redirects.
module ucode_checkpoint_monitor #(
    parameter int PC_W  = 12,
    parameter int N_ENT = 16,
    parameter int CNT_W = 16,
    parameter int LIM_W = 32,
    localparam int IW   = $clog2(N_ENT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [2:0]        cfg_kind,
    input  logic [PC_W-1:0]   cfg_a,
    input  logic [PC_W-1:0]   cfg_b,
    input  logic [PC_W-1:0]   cfg_tgt,
    input  logic [CNT_W-1:0]  cfg_cnt,
    input  logic              enable,
    input  logic [LIM_W-1:0]  limit,
    ucode_checkpoint_monitor_if.slave mon,
    output logic              ev_valid,
    output logic [IW-1:0]     ev_idx,
    output logic [2:0]        ev_kind,
    output logic [N_ENT-1:0]  pass_map,
    output logic [2:0]        state,
    output logic [LIM_W-1:0]  cycles
);

    localparam logic [2:0] K_PASS   = 3'd1;
    localparam logic [2:0] K_FAIL   = 3'd2;
    localparam logic [2:0] K_FINISH = 3'd3;
    localparam logic [2:0] K_SKIP   = 3'd4;
    localparam logic [2:0] K_LOOP   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    state_e state_q, state_d;

    // Checkpoint table plus per-entry loop iteration counters
    logic [2:0]       kind_q [N_ENT];
    logic [2:0]       kind_d [N_ENT];
    logic [PC_W-1:0]  a_q    [N_ENT];
    logic [PC_W-1:0]  a_d    [N_ENT];
    logic [PC_W-1:0]  b_q    [N_ENT];
    logic [PC_W-1:0]  b_d    [N_ENT];
    logic [PC_W-1:0]  tgt_q  [N_ENT];
    logic [PC_W-1:0]  tgt_d  [N_ENT];
    logic [CNT_W-1:0] cnt_q  [N_ENT];
    logic [CNT_W-1:0] cnt_d  [N_ENT];
    logic [CNT_W-1:0] lcnt_q [N_ENT];
    logic [CNT_W-1:0] lcnt_d [N_ENT];

    logic [LIM_W-1:0] cycles_q, cycles_d;
    logic [N_ENT-1:0] pass_map_q, pass_map_d;
    logic             ev_valid_q, ev_valid_d;
    logic [IW-1:0]    ev_idx_q, ev_idx_d;
    logic [2:0]       ev_kind_q, ev_kind_d;
    logic             redir_valid_q, redir_valid_d;
    logic [PC_W-1:0]  redir_pc_q, redir_pc_d;

    logic [N_ENT-1:0] match_s;
    logic             any_hit_s;
    logic             fail_hit_s;
    logic [IW-1:0]    hit_idx_s;
    logic [IW-1:0]    fail_idx_s;
    logic [IW-1:0]    win_idx_s;
    logic [2:0]       win_kind_s;
    logic             hit_s;
    logic             loop_more_s;
    logic             timeout_s;

    // Per-entry match against the retired instruction; kinds 0, 6 and 7 never match
    always_comb begin
        match_s = {N_ENT{1'b0}};
        for (int i = 0; i < N_ENT; i++) begin
            case (kind_q[i])
                K_PASS, K_LOOP:   match_s[i] = mon.ret_cont && (mon.ret_cont_a == a_q[i]);
                K_FAIL, K_FINISH: match_s[i] = (mon.ret_pc == a_q[i]);
                K_SKIP:           match_s[i] = (mon.ret_pc == a_q[i]) && (mon.next_pc == b_q[i]);
                default:          match_s[i] = 1'b0;
            endcase
        end
    end

    // Arbitration: lowest-index FAIL first, otherwise lowest-index match of any kind
    always_comb begin
        any_hit_s  = 1'b0;
        fail_hit_s = 1'b0;
        hit_idx_s  = {IW{1'b0}};
        fail_idx_s = {IW{1'b0}};
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                any_hit_s = 1'b1;
                hit_idx_s = IW'(i);
                if (kind_q[i] == K_FAIL) begin
                    fail_hit_s = 1'b1;
                    fail_idx_s = IW'(i);
                end else begin
                    fail_hit_s = fail_hit_s;
                end
            end else begin
                any_hit_s = any_hit_s;
            end
        end
        win_idx_s  = fail_hit_s ? fail_idx_s : hit_idx_s;
        win_kind_s = kind_q[win_idx_s];
    end

    // Next-state, table update and registered-output computation
    always_comb begin
        state_d       = state_q;
        cycles_d      = cycles_q;
        pass_map_d    = pass_map_q;
        ev_valid_d    = 1'b0;
        ev_idx_d      = ev_idx_q;
        ev_kind_d     = ev_kind_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        kind_d        = kind_q;
        a_d           = a_q;
        b_d           = b_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;
        lcnt_d        = lcnt_q;

        // Retires only count while running with enable still high
        hit_s       = (state_q == ST_RUN) && enable && mon.ret_valid && any_hit_s;
        loop_more_s = ((CNT_W+1)'(lcnt_q[win_idx_s]) + (CNT_W+1)'(1)) < (CNT_W+1)'(cnt_q[win_idx_s]);
        timeout_s   = (limit != {LIM_W{1'b0}}) && (cycles_q == (limit - LIM_W'(1)));

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    kind_d[cfg_idx] = cfg_kind;
                    a_d[cfg_idx]    = cfg_a;
                    b_d[cfg_idx]    = cfg_b;
                    tgt_d[cfg_idx]  = cfg_tgt;
                    cnt_d[cfg_idx]  = cfg_cnt;
                end else begin
                    kind_d = kind_q;
                end
                if (enable) begin
                    state_d    = ST_RUN;
                    cycles_d   = {LIM_W{1'b0}};
                    pass_map_d = {N_ENT{1'b0}};
                    for (int i = 0; i < N_ENT; i++) begin
                        lcnt_d[i] = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cycles_q != {LIM_W{1'b1}}) begin
                        cycles_d = cycles_q + LIM_W'(1);
                    end else begin
                        cycles_d = cycles_q;
                    end
                    // Timeout first so a same-cycle FAIL/FINISH overrides it below
                    if (timeout_s) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        state_d = ST_RUN;
                    end
                    if (hit_s) begin
                        if ((win_kind_s == K_LOOP) && loop_more_s) begin
                            lcnt_d[win_idx_s] = lcnt_q[win_idx_s] + CNT_W'(1);
                            redir_valid_d     = 1'b1;
                            redir_pc_d        = a_q[win_idx_s];
                        end else begin
                            ev_valid_d             = 1'b1;
                            ev_idx_d               = win_idx_s;
                            ev_kind_d              = win_kind_s;
                            pass_map_d[win_idx_s]  = 1'b1;
                            case (win_kind_s)
                                K_FAIL:   state_d = ST_FAIL;
                                K_FINISH: state_d = ST_PASS;
                                K_SKIP: begin
                                    redir_valid_d = 1'b1;
                                    redir_pc_d    = tgt_q[win_idx_s];
                                end
                                K_LOOP:   lcnt_d[win_idx_s] = {CNT_W{1'b0}};
                                default:  state_d = state_d;
                            endcase
                        end
                    end else begin
                        ev_valid_d = 1'b0;
                    end
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, table and output registers; asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cycles_q      <= {LIM_W{1'b0}};
            pass_map_q    <= {N_ENT{1'b0}};
            ev_valid_q    <= 1'b0;
            ev_idx_q      <= {IW{1'b0}};
            ev_kind_q     <= 3'd0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= {PC_W{1'b0}};
            for (int i = 0; i < N_ENT; i++) begin
                kind_q[i] <= 3'd0;
                a_q[i]    <= {PC_W{1'b0}};
                b_q[i]    <= {PC_W{1'b0}};
                tgt_q[i]  <= {PC_W{1'b0}};
                cnt_q[i]  <= {CNT_W{1'b0}};
                lcnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            cycles_q      <= cycles_d;
            pass_map_q    <= pass_map_d;
            ev_valid_q    <= ev_valid_d;
            ev_idx_q      <= ev_idx_d;
            ev_kind_q     <= ev_kind_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            kind_q        <= kind_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tgt_q         <= tgt_d;
            cnt_q         <= cnt_d;
            lcnt_q        <= lcnt_d;
        end
    end

    assign state           = state_q;
    assign cycles          = cycles_q;
    assign pass_map        = pass_map_q;
    assign ev_valid        = ev_valid_q;
    assign ev_idx          = ev_idx_q;
    assign ev_kind         = ev_kind_q;
    assign mon.redir_valid = redir_valid_q;
    assign mon.redir_pc    = redir_pc_q;

endmodule
